// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock/strobe divider
// Each channel divides clk_i by a runtime period; new periods apply only at a period boundary.
module clk_div_multi #(
  parameter int NCH      = 2,
  parameter int CNT_W    = 24,
  parameter int DIV_INIT = 100000
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NCH-1:0]       en_i,
  input  logic [NCH*CNT_W-1:0] div_i,
  input  logic [NCH-1:0]       div_load_i,
  output logic [NCH-1:0]       div_pend_o,
  output logic [NCH-1:0]       clk_o,
  output logic [NCH-1:0]       tick_o
);

  localparam logic [CNT_W-1:0] INIT_DIV = CNT_W'(DIV_INIT);
  localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic [CNT_W-1:0] eff, div_k;
    logic             run_q, pend_q, pend_d;
    logic             clk_q, clk_d, tick_q, tick_d;
    logic             wrap;

    always_comb begin
      div_k  = div_i[k*CNT_W +: CNT_W];
      eff    = (act_q < MIN_DIV) ? MIN_DIV : act_q;
      // run_q separates "counting at 0" from "idle at 0" so the first enabled cycle is a fresh period
      wrap   = en_i[k] && run_q && (cnt_q == eff - ONE);
      cnt_d  = '0;
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      if (!en_i[k]) begin
        if (div_load_i[k]) begin
          shd_d  = div_k;
          pend_d = 1'b1;
        end else if (pend_q) begin
          act_d  = shd_q;
          pend_d = 1'b0;
        end
      end else if (wrap) begin
        // a load landing on the wrap itself takes effect immediately
        if (div_load_i[k]) begin
          act_d  = div_k;
          pend_d = 1'b0;
        end else if (pend_q) begin
          act_d  = shd_q;
          pend_d = 1'b0;
        end
      end else begin
        if (run_q) cnt_d = cnt_q + ONE;
        if (div_load_i[k]) begin
          shd_d  = div_k;
          pend_d = 1'b1;
        end
      end
      // at a wrap cnt_d is 0, which is high for any period, so the old eff is safe here
      clk_d  = en_i[k] && (cnt_d < (eff >> 1));
      tick_d = en_i[k] && (cnt_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt_q  <= '0;
        act_q  <= INIT_DIV;
        shd_q  <= INIT_DIV;
        run_q  <= 1'b0;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        run_q  <= en_i[k];
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_o[k]      = clk_q;
    assign tick_o[k]     = tick_q;
    assign div_pend_o[k] = pend_q;
  end

endmodule
